// File: rtl/jk_pkg.sv
// Shared JK flip-flop types: operation encoding and next-state rule.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_t;

  // Next-state bit for one JK flop given its {J,K} operation and current state.
  function automatic logic jk_next(input jk_op_t op, input logic q);
    logic nxt;
    nxt = q;
    case (op)
      HOLD:    nxt = q;
      CLR:     nxt = 1'b0;
      SET:     nxt = 1'b1;
      TGL:     nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flop with synchronous active-high reset to RST_VAL.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_op_t op;

  always_comb begin
    op = jk_op_t'({j, k});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= jk_next(op, q);
    end
  end

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flops with complementary outputs.
module jk_ff
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  input  logic             clk,
  input  logic             rst
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .j   (J[i]),
      .k   (K[i]),
      .q   (Q[i])
    );
  end

  // Complement is derived combinationally so it can never disagree with Q.
  assign Qbar = ~Q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed self-checking bench for jk_ff at WIDTH=1 and WIDTH=4.
module tb_jk_ff;

  logic       clk;
  logic       rst1, rst4;
  logic [0:0] j1, k1, q1, qb1;
  logic [3:0] j4, k4, q4, qb4;

  int checks;
  int failures;

  jk_ff #(.WIDTH(1)) u_dut1 (
    .J(j1), .K(k1), .Q(q1), .Qbar(qb1), .clk(clk), .rst(rst1)
  );

  jk_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .J(j4), .K(k4), .Q(q4), .Qbar(qb4), .clk(clk), .rst(rst4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic e);
    check({tag, "_q"},    {3'b000, q1},  {3'b000, e});
    check({tag, "_qbar"}, {3'b000, qb1}, {3'b000, ~e});
  endtask

  task automatic chk4(input string tag, input logic [3:0] e);
    check({tag, "_q4"},    q4,  e);
    check({tag, "_qbar4"}, qb4, ~e);
  endtask

  // Advance to the next rising edge and settle 1 ns past it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
    rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;

    // Reset held for two edges with J=K=1: no toggling.
    edge_step(); chk1("rst_e1", 1'b0); chk4("rst_e1", 4'b1010);
    edge_step(); chk1("rst_e2", 1'b0); chk4("rst_e2", 4'b1010);

    rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    rst4 = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
    edge_step(); chk1("hold0", 1'b0); chk4("vec_a", 4'b1011);

    // Set, then toggle twice, then hold.
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b0101; k4 = 4'b0011;
    edge_step(); chk1("set", 1'b1); chk4("vec_b", 4'b1100);

    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;
    edge_step(); chk1("tgl1", 1'b0); chk4("tgl4_1", 4'b0011);
    edge_step(); chk1("tgl2", 1'b1); chk4("tgl4_2", 4'b1100);

    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    edge_step(); chk1("hold1a", 1'b1);
    edge_step(); chk1("hold1b", 1'b1); chk4("hold4", 4'b1100);

    // Clear then hold for three edges.
    j1 = 1'b0; k1 = 1'b1;
    edge_step(); chk1("clr", 1'b0);
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step(); chk1("clr_hold", 1'b0);
    end

    // Mid-cycle pulses while clk is high must not reach Q.
    j1 = 1'b1; rst4 = 1'b1;
    #2;
    j1 = 1'b0; rst4 = 1'b0;
    edge_step(); chk1("glitch", 1'b0); chk4("glitch4", 4'b1100);

    // Synchronous reset in the middle of a toggle run.
    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;
    edge_step(); chk1("rt_t1", 1'b1); chk4("rt4_t1", 4'b0011);
    rst4 = 1'b1;
    edge_step(); chk1("rt_t2", 1'b0); chk4("rt4_rst", 4'b1010);
    rst1 = 1'b1; rst4 = 1'b0;
    edge_step(); chk1("rt_rst", 1'b0); chk4("rt4_t3", 4'b0101);
    rst1 = 1'b0;
    edge_step(); chk1("rt_t3", 1'b1); chk4("rt4_t4", 4'b1010);
    edge_step(); chk1("rt_t4", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
